eth_axil_master: RTL and testbench

Single-outstanding AXI4-Lite initiator that drives the `axi_ethernetlite_0` register slave on behalf of local control logic (MDIO/PHY setup, TX/RX buffer access). A simple valid/ready command port is converted into one AXI4-Lite read or write transaction. The response (data, BRESP/RRESP, timeout flag) comes back on a valid/ready response port. It sits between the board control FSM and the Ethernet-lite IP inside the Ethernet top level.

---
 rtl/eth_axil_pkg.sv | 19 +
 rtl/eth_axil_master.sv | 200 ++++++++++++++++++++
 tb/tb_eth_axil_master.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_axil_pkg.sv
// Shared types and constants for the Ethernet-lite AXI4-Lite initiator.
//   axil_state_t : transaction FSM states
//   AXI_RESP_*   : AXI4-Lite BRESP/RRESP encodings
package eth_axil_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_ADDR,
      S_WR_RESP,
      S_RD_ADDR,
      S_RD_DATA,
      S_RESP
   } axil_state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/eth_axil_master.sv
// Single-outstanding AXI4-Lite initiator for the axi_ethernetlite_0 register
// slave. One command on the cmd_* port becomes one AXI4-Lite read or write;
// the result returns on the rsp_* port.
//   clk, rst (async, active-low)
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata/cmd_wstrb : command in
//   rsp_valid/rsp_ready/rsp_rdata/rsp_resp/rsp_timeout         : response out
//   bus_hung                                                    : sticky hang flag
//   m_axi_*                                                     : AXI4-Lite master
module eth_axil_master
   import eth_axil_pkg::*;
#(
   parameter int unsigned P_AXI_ADDR_WIDTH = 32,
   parameter int unsigned P_AXI_DATA_WIDTH = 32,
   parameter int unsigned P_TIMEOUT_CYCLES = 1023
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_write,
   input  logic [P_AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [P_AXI_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [P_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [P_AXI_DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]                    rsp_resp,
   output logic                          rsp_timeout,
   output logic                          bus_hung,
   output logic [P_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [P_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [P_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   input  logic [1:0]                    m_axi_bresp,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready,
   output logic [P_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   input  logic [P_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready
);

   localparam int unsigned CNT_MIN  = 11;
   localparam int unsigned CNT_CLOG = $clog2(P_TIMEOUT_CYCLES + 1);
   localparam int unsigned CNT_W    = (CNT_CLOG > CNT_MIN) ? CNT_CLOG : CNT_MIN;
   localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(P_TIMEOUT_CYCLES);

   axil_state_t      state;
   logic [CNT_W-1:0] tmo_cnt;
   logic             aw_done, w_done;
   logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic             aw_fin, w_fin;
   logic             busy, advance, tmo_hit;

   assign aw_hs   = m_axi_awvalid && m_axi_awready;
   assign w_hs    = m_axi_wvalid  && m_axi_wready;
   assign b_hs    = m_axi_bvalid  && m_axi_bready;
   assign ar_hs   = m_axi_arvalid && m_axi_arready;
   assign r_hs    = m_axi_rvalid  && m_axi_rready;
   assign aw_fin  = aw_done || aw_hs;
   assign w_fin   = w_done  || w_hs;
   assign tmo_hit = (tmo_cnt == TMO_LIMIT);

   // busy: a bus phase is pending; advance: that phase completes this cycle
   always_comb begin
      busy    = 1'b0;
      advance = 1'b0;
      case (state)
         S_WR_ADDR: begin busy = 1'b1; advance = aw_fin && w_fin; end
         S_WR_RESP: begin busy = 1'b1; advance = b_hs;            end
         S_RD_ADDR: begin busy = 1'b1; advance = ar_hs;           end
         S_RD_DATA: begin busy = 1'b1; advance = r_hs;            end
         default:   begin busy = 1'b0; advance = 1'b0;            end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         tmo_cnt       <= '0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         cmd_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_resp      <= AXI_RESP_OKAY;
         rsp_timeout   <= 1'b0;
         bus_hung      <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
      end else begin
         // Valids drop on their own handshake in any state, so a slave that
         // finally accepts after a timeout still sees a legal AXI exchange.
         if (aw_hs) m_axi_awvalid <= 1'b0;
         if (w_hs)  m_axi_wvalid  <= 1'b0;
         if (ar_hs) m_axi_arvalid <= 1'b0;

         if (busy) tmo_cnt <= tmo_cnt + 1'b1;

         case (state)
            S_IDLE: begin
               tmo_cnt   <= '0;
               aw_done   <= 1'b0;
               w_done    <= 1'b0;
               cmd_ready <= !bus_hung;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready    <= 1'b0;
                  m_axi_awaddr <= cmd_addr;
                  m_axi_araddr <= cmd_addr;
                  m_axi_wdata  <= cmd_wdata;
                  m_axi_wstrb  <= cmd_wstrb;
                  if (cmd_addr[1:0] != 2'b00) begin
                     rsp_valid   <= 1'b1;
                     rsp_rdata   <= '0;
                     rsp_resp    <= AXI_RESP_SLVERR;
                     rsp_timeout <= 1'b0;
                     state       <= S_RESP;
                  end else if (cmd_write) begin
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                     state         <= S_WR_ADDR;
                  end else begin
                     m_axi_arvalid <= 1'b1;
                     state         <= S_RD_ADDR;
                  end
               end
            end
            S_WR_ADDR: begin
               aw_done <= aw_fin;
               w_done  <= w_fin;
               if (advance) begin
                  m_axi_bready <= 1'b1;
                  state        <= S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               if (advance) begin
                  m_axi_bready <= 1'b0;
                  rsp_valid    <= 1'b1;
                  rsp_rdata    <= '0;
                  rsp_resp     <= m_axi_bresp;
                  rsp_timeout  <= 1'b0;
                  state        <= S_RESP;
               end
            end
            S_RD_ADDR: begin
               if (advance) begin
                  m_axi_rready <= 1'b1;
                  state        <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (advance) begin
                  m_axi_rready <= 1'b0;
                  rsp_valid    <= 1'b1;
                  rsp_rdata    <= m_axi_rdata;
                  rsp_resp     <= m_axi_rresp;
                  rsp_timeout  <= 1'b0;
                  state        <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= !bus_hung;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         // A handshake landing on the limit cycle wins: the slave has already
         // consumed it, so the transaction completes normally.
         if (busy && !advance && tmo_hit) begin
            m_axi_bready <= 1'b0;
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= AXI_RESP_SLVERR;
            rsp_timeout  <= 1'b1;
            bus_hung     <= 1'b1;
            state        <= S_RESP;
         end
      end
   end

endmodule

// File: tb/tb_eth_axil_master.sv
// Directed self-checking bench for eth_axil_master with a parameterisable
// wait-state AXI4-Lite slave model. Inputs are driven and outputs sampled on
// the falling clock edge.
module tb_eth_axil_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout, bus_hung;
   logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
   logic        m_axi_awready = 1'b0;
   logic        m_axi_wready  = 1'b0;
   logic        m_axi_bvalid  = 1'b0;
   logic        m_axi_arready = 1'b0;
   logic        m_axi_rvalid  = 1'b0;
   logic [1:0]  m_axi_bresp   = 2'b00;
   logic [1:0]  m_axi_rresp   = 2'b00;
   logic [31:0] m_axi_rdata   = '0;

   int checks = 0;
   int errors = 0;

   eth_axil_master #(
      .P_AXI_ADDR_WIDTH(32),
      .P_AXI_DATA_WIDTH(32),
      .P_TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .bus_hung(bus_hung),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready)
   );

   logic [42:0] out_vec;
   assign out_vec = {cmd_ready, rsp_valid, rsp_timeout, bus_hung, m_axi_awvalid, m_axi_wvalid,
                     m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_resp, rsp_rdata};

   // ---------------- slave model ----------------
   int unsigned aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   logic [31:0] s_rdata = '0;
   logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;
   int unsigned aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, bready_early = 0;
   int unsigned aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;

   // Ready/valid decided at the falling edge; a handshake counted here takes
   // place on the following rising edge. B/R are evaluated before AW/W/AR so
   // a response never appears in the same cycle as its address handshake.
   always @(negedge clk) begin
      if (!rst) begin
         m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
         m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; bready_early = 0;
         aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      end else begin
         if (aw_cnt > b_cnt && w_cnt > b_cnt) begin
            m_axi_bresp = s_bresp;
            if (b_wait >= b_delay) begin
               m_axi_bvalid = 1'b1;
               if (m_axi_bready) begin b_cnt++; b_wait = 0; end
            end else begin
               m_axi_bvalid = 1'b0; b_wait++;
            end
         end else m_axi_bvalid = 1'b0;

         if (ar_cnt > r_cnt) begin
            m_axi_rdata = s_rdata; m_axi_rresp = s_rresp;
            if (r_wait >= r_delay) begin
               m_axi_rvalid = 1'b1;
               if (m_axi_rready) begin r_cnt++; r_wait = 0; end
            end else begin
               m_axi_rvalid = 1'b0; r_wait++;
            end
         end else m_axi_rvalid = 1'b0;

         if (m_axi_bready && (m_axi_awvalid || m_axi_wvalid)) bready_early++;

         if (m_axi_awvalid) begin
            if (aw_wait >= aw_delay) begin m_axi_awready = 1'b1; aw_cnt++; aw_wait = 0; end
            else begin m_axi_awready = 1'b0; aw_wait++; end
         end else m_axi_awready = 1'b0;
         if (m_axi_wvalid) begin
            if (w_wait >= w_delay) begin m_axi_wready = 1'b1; w_cnt++; w_wait = 0; end
            else begin m_axi_wready = 1'b0; w_wait++; end
         end else m_axi_wready = 1'b0;
         if (m_axi_arvalid) begin
            if (ar_wait >= ar_delay) begin m_axi_arready = 1'b1; ar_cnt++; ar_wait = 0; end
            else begin m_axi_arready = 1'b0; ar_wait++; end
         end else m_axi_arready = 1'b0;
      end
   end

   // ---------------- drivers ----------------
   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int unsigned ok);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (cmd_ready) begin ok = 1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Returns the cycle (acceptance = cycle 0) in which rsp_valid was first
   // seen, then holds rsp_ready low for 'hold' cycles and captures at handshake.
   task automatic wait_rsp(input int unsigned hold, output int unsigned lat,
                           output logic [31:0] rd, output logic [1:0] rr, output logic to);
      lat = 1;
      while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
      if (!rsp_valid) begin
         lat = 999; rd = '0; rr = 2'b00; to = 1'b0;
      end else begin
         repeat (hold) @(negedge clk);
         rd = rsp_rdata; rr = rsp_resp; to = rsp_timeout;
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (out_vec !== 43'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", out_vec); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
      checks++; if (bus_hung !== 1'b0) begin errors++; $display("FAIL reset_bus_hung got %b want 0", bus_hung); end
   endtask

   task automatic test_zero_read();
      int unsigned ok, lat; logic [31:0] rd; logic [1:0] rr; logic to;
      ar_delay = 0; r_delay = 0; s_rdata = 32'h1234_5678; s_rresp = 2'b00;
      issue(1'b0, 32'h0000_07E4, 32'h0, 4'h0, ok);
      checks++; if (ok !== 1) begin errors++; $display("FAIL zr_accept got %0d want 1", ok); end
      checks++; if ({m_axi_arvalid, m_axi_awvalid, m_axi_araddr} !== {2'b10, 32'h0000_07E4})
         begin errors++; $display("FAIL zr_ar_cycle1 got %b%b %h want 10 000007e4", m_axi_arvalid, m_axi_awvalid, m_axi_araddr); end
      wait_rsp(0, lat, rd, rr, to);
      checks++; if (lat !== 3) begin errors++; $display("FAIL zr_latency got %0d want 3", lat); end
      checks++; if ({rd, rr, to} !== {32'h1234_5678, 2'b00, 1'b0})
         begin errors++; $display("FAIL zr_rsp got %h %b %b want 12345678 00 0", rd, rr, to); end
   endtask

   task automatic test_zero_write();
      int unsigned ok, lat; logic [31:0] rd; logic [1:0] rr; logic to;
      aw_delay = 0; w_delay = 0; b_delay = 0; s_bresp = 2'b00;
      issue(1'b1, 32'h0000_07F4, 32'h0000_0001, 4'hF, ok);
      checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !==
                    {2'b11, 32'h0000_07F4, 32'h0000_0001, 4'hF})
         begin errors++; $display("FAIL zw_aw_w_cycle1 got %b%b %h %h %h want 11 000007f4 00000001 f",
                                  m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, m_axi_wdata, m_axi_wstrb); end
      wait_rsp(0, lat, rd, rr, to);
      checks++; if (lat !== 3) begin errors++; $display("FAIL zw_latency got %0d want 3", lat); end
      checks++; if ({rd, rr, to} !== {32'h0, 2'b00, 1'b0})
         begin errors++; $display("FAIL zw_rsp got %h %b %b want 00000000 00 0", rd, rr, to); end
   endtask

   task automatic test_aw_w_skew();
      int unsigned awd [2] = '{3, 0};
      int unsigned wd  [2] = '{0, 3};
      logic [1:0]  br  [2] = '{2'b00, 2'b11};
      int unsigned ok, lat, aw0, w0, be0; logic [31:0] rd; logic [1:0] rr; logic to;
      for (int k = 0; k < 2; k++) begin
         aw_delay = awd[k]; w_delay = wd[k]; s_bresp = br[k];
         aw0 = aw_cnt; w0 = w_cnt; be0 = bready_early;
         issue(1'b1, 32'h0000_0100, 32'hCAFE_0000 + k, 4'h3, ok);
         wait_rsp(0, lat, rd, rr, to);
         checks++; if (lat !== 6) begin errors++; $display("FAIL skew%0d_latency got %0d want 6", k, lat); end
         checks++; if ({aw_cnt - aw0, w_cnt - w0} !== {32'd1, 32'd1})
            begin errors++; $display("FAIL skew%0d_handshakes got aw %0d w %0d want 1 1", k, aw_cnt - aw0, w_cnt - w0); end
         checks++; if (bready_early - be0 !== 0)
            begin errors++; $display("FAIL skew%0d_bready_early got %0d want 0", k, bready_early - be0); end
         checks++; if (rr !== br[k]) begin errors++; $display("FAIL skew%0d_bresp got %b want %b", k, rr, br[k]); end
      end
      aw_delay = 0; w_delay = 0; s_bresp = 2'b00;
   endtask

   task automatic test_delayed_read();
      int unsigned ok, lat; logic [31:0] rd; logic [1:0] rr; logic to;
      ar_delay = 0; r_delay = 5; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b10;
      issue(1'b0, 32'h0000_07E4, 32'h0, 4'h0, ok);
      wait_rsp(3, lat, rd, rr, to);
      checks++; if (lat !== 8) begin errors++; $display("FAIL dr_latency got %0d want 8", lat); end
      checks++; if ({rd, rr, to} !== {32'hDEAD_BEEF, 2'b10, 1'b0})
         begin errors++; $display("FAIL dr_rsp_held got %h %b %b want deadbeef 10 0", rd, rr, to); end
      r_delay = 0; s_rresp = 2'b00;
   endtask

   task automatic test_misaligned();
      int unsigned ok, lat, n0; logic [31:0] rd; logic [1:0] rr; logic to; logic vseen;
      n0 = aw_cnt + w_cnt + ar_cnt;
      issue(1'b0, 32'h0000_0002, 32'h0, 4'h0, ok);
      vseen = m_axi_awvalid | m_axi_wvalid | m_axi_arvalid;
      wait_rsp(0, lat, rd, rr, to);
      for (int i = 0; i < 3; i++) begin
         vseen = vseen | m_axi_awvalid | m_axi_wvalid | m_axi_arvalid;
         @(negedge clk);
      end
      checks++; if (!(lat inside {[1:2]})) begin errors++; $display("FAIL mis_latency got %0d want 1..2", lat); end
      checks++; if ({rr, to} !== {2'b10, 1'b0}) begin errors++; $display("FAIL mis_rsp got %b %b want 10 0", rr, to); end
      checks++; if ({vseen, aw_cnt + w_cnt + ar_cnt - n0} !== {1'b0, 32'd0})
         begin errors++; $display("FAIL mis_no_bus got valid %b hs %0d want 0 0", vseen, aw_cnt + w_cnt + ar_cnt - n0); end
   endtask

   task automatic test_back_to_back();
      int unsigned ok, lat; logic [31:0] rd; logic [1:0] rr; logic to;
      issue(1'b1, 32'h0000_0010, 32'h1111_1111, 4'hF, ok);
      wait_rsp(0, lat, rd, rr, to);
      checks++; if ({cmd_ready, rsp_valid} !== 2'b10)
         begin errors++; $display("FAIL b2b_ready_after_rsp got %b%b want 10", cmd_ready, rsp_valid); end
      issue(1'b1, 32'h0000_0014, 32'h2222_2222, 4'hF, ok);
      checks++; if (m_axi_wdata !== 32'h2222_2222) begin errors++; $display("FAIL b2b_wdata got %h want 22222222", m_axi_wdata); end
      wait_rsp(0, lat, rd, rr, to);
      checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_latency got %0d want 3", lat); end
   endtask

   task automatic test_reset_mid();
      int unsigned ok, lat, n; logic [31:0] rd; logic [1:0] rr; logic to;
      r_delay = 1000;
      issue(1'b0, 32'h0000_07E8, 32'h0, 4'h0, ok);
      n = 0;
      while (!m_axi_rready && n < 10) begin @(negedge clk); n++; end
      checks++; if (m_axi_rready !== 1'b1) begin errors++; $display("FAIL rm_rd_data_reached got %b want 1", m_axi_rready); end
      rst = 1'b0;
      #1;
      checks++; if (out_vec !== 43'd0) begin errors++; $display("FAIL rm_outputs got %h want 0", out_vec); end
      @(negedge clk); @(negedge clk);
      rst = 1'b1; r_delay = 0; s_rdata = 32'hA5A5_5A5A; s_rresp = 2'b00;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_cmd_ready got %b want 1", cmd_ready); end
      issue(1'b0, 32'h0000_07E0, 32'h0, 4'h0, ok);
      wait_rsp(0, lat, rd, rr, to);
      checks++; if ({lat, rd, rr} !== {32'd3, 32'hA5A5_5A5A, 2'b00})
         begin errors++; $display("FAIL rm_read_after got %0d %h %b want 3 a5a55a5a 00", lat, rd, rr); end
   endtask

   task automatic test_timeout();
      int unsigned ok, lat; logic [31:0] rd; logic [1:0] rr; logic to; logic rdy_seen;
      aw_delay = 100000; w_delay = 0;
      issue(1'b1, 32'h0000_07F0, 32'h0000_00FF, 4'hF, ok);
      wait_rsp(2, lat, rd, rr, to);
      checks++; if (lat !== 18) begin errors++; $display("FAIL to_latency got %0d want 18", lat); end
      checks++; if ({to, rr, rd} !== {1'b1, 2'b10, 32'h0})
         begin errors++; $display("FAIL to_rsp got %b %b %h want 1 10 00000000", to, rr, rd); end
      checks++; if ({bus_hung, m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 4'b1100)
         begin errors++; $display("FAIL to_bus_state got %b%b%b%b want 1100", bus_hung, m_axi_awvalid, m_axi_wvalid, m_axi_bready); end
      rdy_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin rdy_seen = rdy_seen | cmd_ready; @(negedge clk); end
      checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL to_cmd_ready_held got %b want 0", rdy_seen); end
      rst = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b1; aw_delay = 0;
      @(negedge clk);
      checks++; if ({cmd_ready, bus_hung, m_axi_awvalid} !== 3'b100)
         begin errors++; $display("FAIL to_reset_clear got %b%b%b want 100", cmd_ready, bus_hung, m_axi_awvalid); end
   endtask

   initial begin
      rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_wstrb = '0; rsp_ready = 1'b0;
      test_reset();
      test_zero_read();
      test_zero_write();
      test_aw_w_skew();
      test_delayed_read();
      test_misaligned();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "bench watchdog expired");
   end

endmodule
